// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch-side initiator for a word-addressed instruction memory. Owns the fetch
// PC, presents it to the memory, captures the combinationally returned word
// into a small prefetch FIFO and hands {pc, instruction} to decode over a
// valid/ready handshake. A redirect flushes the FIFO and restarts fetch.
//
// Parameters
//   RESET_PC    fetch PC loaded on reset (word aligned)
//   FIFO_DEPTH  prefetch entries, power of 2, >= 2
//
// Ports
//   clk               in   rising-edge clock
//   rst_n             in   asynchronous active-low reset
//   fetch_enable      in   1 = fetch allowed this cycle
//   imem_address      out  byte address to instruction memory (= fetch PC)
//   imem_instruction  in   word at imem_address, valid in the same cycle
//   redirect_valid    in   single-cycle pulse: flush and restart at redirect_pc
//   redirect_pc       in   new fetch address
//   out_valid         out  FIFO head holds a valid entry
//   out_ready         in   decode accepts the head when out_valid & out_ready
//   out_pc            out  PC of the head entry
//   out_instruction   out  instruction of the head entry
//   fetch_fault       out  sticky misaligned-redirect flag
//
// Optional feature
//   IFU_MISALIGN_TRAP_EN  when defined, a redirect to a non-word-aligned PC
//                         sets fetch_fault and halts fetch until the next
//                         aligned redirect. When undefined the low two bits
//                         of redirect_pc are dropped and fetch_fault is 0.
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_enable,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_instruction,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instruction,
   output logic        fetch_fault
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [PTR_W-1:0] wr_q, wr_d;

   logic [31:0] fifo_pc_q  [FIFO_DEPTH];
   logic [31:0] fifo_ins_q [FIFO_DEPTH];

   logic pop;
   logic push;
   logic halted;

`ifdef IFU_MISALIGN_TRAP_EN
   logic halted_q, halted_d;
   logic fault_q, fault_d;

   assign halted      = halted_q;
   assign fetch_fault = fault_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         halted_q <= halted_d;
         fault_q  <= fault_d;
      end
   end
`else
   // Only the word-address bits of a redirect target are meaningful here.
   logic unused_redirect_bits;

   assign unused_redirect_bits = ^redirect_pc[1:0];
   assign halted               = 1'b0;
   assign fetch_fault          = 1'b0;
`endif

   assign imem_address    = fetch_pc_q;
   assign out_valid       = (cnt_q != '0);
   assign out_pc          = fifo_pc_q[rd_q];
   assign out_instruction = fifo_ins_q[rd_q];

   assign pop  = out_valid & out_ready;
   // A full FIFO may still accept a word in a cycle where decode drains one.
   assign push = fetch_enable & ~redirect_valid & ~halted
               & ((cnt_q < CNT_W'(FIFO_DEPTH)) | pop);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      cnt_d      = cnt_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
`ifdef IFU_MISALIGN_TRAP_EN
      halted_d   = halted_q;
      fault_d    = fault_q;
`endif

      if (redirect_valid) begin
         // Redirect wins over any handshake in the same cycle.
         cnt_d = '0;
         rd_d  = '0;
         wr_d  = '0;
`ifdef IFU_MISALIGN_TRAP_EN
         if (redirect_pc[1:0] != 2'b00) begin
            halted_d = 1'b1;
            fault_d  = 1'b1;
         end else begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            halted_d   = 1'b0;
            fault_d    = 1'b0;
         end
`else
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
`endif
      end else begin
         if (push) begin
            wr_d       = wr_q + PTR_W'(1);
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (pop) begin
            rd_d = rd_q + PTR_W'(1);
         end
         if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
         end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         cnt_q      <= '0;
         rd_q       <= '0;
         wr_q       <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
      end
   end

   // Storage is reset so the head reads as zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_pc_q[i]  <= '0;
            fifo_ins_q[i] <= '0;
         end
      end else if (push) begin
         fifo_pc_q[wr_q]  <= fetch_pc_q;
         fifo_ins_q[wr_q] <= imem_instruction;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic        fetch_enable;
   logic [31:0] imem_address;
   logic [31:0] imem_instruction;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instruction;
   logic        fetch_fault;

   int passed = 0;
   int total  = 0;

   instruction_fetch_unit #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .fetch_enable     (fetch_enable),
      .imem_address     (imem_address),
      .imem_instruction (imem_instruction),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_pc           (out_pc),
      .out_instruction  (out_instruction),
      .fetch_fault      (fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory[i] = i + 1 for word index i
   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a >> 2) + 32'd1;
   endfunction

   assign imem_instruction = mem(imem_address);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: a queue of buffered words plus the next fetch address.
   logic [31:0] mq_pc  [$];
   logic [31:0] mq_ins [$];
   logic [31:0] m_pc;
   logic        m_fault;
   logic        m_halt;

   task automatic model_reset();
      mq_pc.delete();
      mq_ins.delete();
      m_pc    = RST_PC;
      m_fault = 1'b0;
      m_halt  = 1'b0;
   endtask

   // Called at a negedge: compare, drive one cycle of inputs, advance model.
   task automatic step(input logic fe, input logic rdy, input logic rv,
                       input logic [31:0] rpc);
      logic has;
      logic pop;
      logic room;
      has = (mq_pc.size() != 0);
      chk("out_valid", 32'(out_valid), 32'(has));
      chk("imem_address", imem_address, m_pc);
      chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
      if (has) begin
         chk("out_pc", out_pc, mq_pc[0]);
         chk("out_instruction", out_instruction, mq_ins[0]);
      end
      fetch_enable   = fe;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      pop  = has && rdy;
      room = (mq_pc.size() < DEPTH) || pop;
      if (rv) begin
         mq_pc.delete();
         mq_ins.delete();
`ifdef IFU_MISALIGN_TRAP_EN
         if (rpc[1:0] != 2'b00) begin
            m_fault = 1'b1;
            m_halt  = 1'b1;
         end else begin
            m_pc    = rpc & 32'hFFFF_FFFC;
            m_fault = 1'b0;
            m_halt  = 1'b0;
         end
`else
         m_pc = rpc & 32'hFFFF_FFFC;
`endif
      end else begin
         if (pop) begin
            void'(mq_pc.pop_front());
            void'(mq_ins.pop_front());
         end
         if (fe && room && !m_halt) begin
            mq_pc.push_back(m_pc);
            mq_ins.push_back(mem(m_pc));
            m_pc = m_pc + 32'd4;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic        fe;
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        exp_v;
      logic        chk_d;
      logic [31:0] exp_pc;
      logic [31:0] exp_ins;
      logic [31:0] exp_addr;
   } vec_t;

   vec_t tbl [10];

   initial begin
      // Expected values are the outputs seen before the row's inputs take effect.
      //          fe    rdy   rv    rpc      v     chkd  pc       ins    addr
      tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  32'd0,  32'h00};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  32'd1,  32'h04};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h4,  32'd2,  32'h08};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h4,  32'd2,  32'h0C};
      tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h4,  32'd2,  32'h0C};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h8,  32'd3,  32'h10};
      tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'hC,  32'd4,  32'h10};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'd0,  32'h10};
      tbl[8] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'd0,  32'h40};
      tbl[9] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 32'd17, 32'h44};

      rst_n          = 1'b0;
      fetch_enable   = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      model_reset();

      #1;
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_pc", out_pc, 32'h0);
      chk("rst out_instruction", out_instruction, 32'h0);
      chk("rst imem_address", imem_address, RST_PC);
      chk("rst fetch_fault", 32'(fetch_fault), 32'd0);

      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         chk($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].exp_v));
         chk($sformatf("tbl%0d imem_address", i), imem_address, tbl[i].exp_addr);
         if (tbl[i].chk_d) begin
            chk($sformatf("tbl%0d out_pc", i), out_pc, tbl[i].exp_pc);
            chk($sformatf("tbl%0d out_instruction", i), out_instruction, tbl[i].exp_ins);
         end
         fetch_enable   = tbl[i].fe;
         out_ready      = tbl[i].rdy;
         redirect_valid = tbl[i].rv;
         redirect_pc    = tbl[i].rpc;
         @(posedge clk);
         @(negedge clk);
      end

      // Fill the FIFO, then reset asynchronously between edges.
      fetch_enable   = 1'b1;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("pre-reset out_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst out_valid", 32'(out_valid), 32'd0);
      chk("async rst imem_address", imem_address, RST_PC);
      chk("async rst out_pc", out_pc, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Stall decode for 5 cycles: FIFO holds DEPTH words, address frozen.
      repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("stall imem_address", imem_address, RST_PC + 32'(4 * DEPTH));
      chk("stall depth", 32'(mq_pc.size()), 32'(DEPTH));
      repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);

      // Redirect while full and popping.
      repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 32'h40);
      chk("redir flush out_valid", 32'(out_valid), 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("redir out_pc", out_pc, 32'h40);
      chk("redir out_instruction", out_instruction, 32'd17);
      chk("redir out_valid", 32'(out_valid), 32'd1);

      // PC wrap at the top of the address space.
      step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("wrap pc0", out_pc, 32'hFFFF_FFF8);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("wrap pc1", out_pc, 32'hFFFF_FFFC);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("wrap pc2", out_pc, 32'h0000_0000);
      chk("wrap ins2", out_instruction, 32'd1);

`ifdef IFU_MISALIGN_TRAP_EN
      step(1'b1, 1'b1, 1'b1, 32'h22);
      chk("trap fault", 32'(fetch_fault), 32'd1);
      chk("trap out_valid", 32'(out_valid), 32'd0);
      repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("halted out_valid", 32'(out_valid), 32'd0);
      step(1'b1, 1'b1, 1'b1, 32'h20);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("resume fault", 32'(fetch_fault), 32'd0);
      chk("resume out_pc", out_pc, 32'h20);
`endif

      // Randomized traffic against the queue model.
      for (int n = 0; n < 400; n++) begin
         logic        fe;
         logic        rdy;
         logic        rv;
         logic [31:0] rpc;
         fe  = ($urandom_range(3) != 0);
         rdy = ($urandom_range(2) != 0);
         rv  = ($urandom_range(15) == 0);
         rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                        : 32'($urandom_range(1023));
         step(fe, rdy, rv, rpc);
      end
      step(1'b0, 1'b0, 1'b0, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
